// File: rtl/iter_counter.sv
// rtl/iter_counter.sv - parametrised iteration counter for the shift-add multiplier
//
// Gives the multiplier control FSM a step index, a last-iteration flag,
// a sticky terminal flag and a one-cycle completion pulse.
//
// Optional feature macro: ITER_COUNTER_LEN_EN
//   defined   : the length is taken from i_len at Load (0 or > N_BITS clamps to N_BITS)
//   undefined : i_len is ignored and the length is always N_BITS
//
// Parameters:
//   N_BITS  operand width and maximum iteration count (>= 2)
//   CNT_W   width of the count and length fields
//
// Ports:
//   i_clk    clock, rising edge
//   i_rst    synchronous active-high reset, dominates all other inputs
//   i_load   start (or restart) an operation, latches the effective length
//   i_step   advance the count by one while running
//   i_abort  cancel the operation and return to IDLE
//   i_len    requested iteration count (used only with ITER_COUNTER_LEN_EN)
//   o_cnt    current iteration index, 0 .. L-1
//   o_last   high while running with o_cnt == L-1
//   o_k      terminal flag, sticky until the next Load, Abort or reset
//   o_busy   high in the RUN state
//   o_done   one-cycle pulse when the final step is accepted

module iter_counter #(
  parameter int N_BITS = 8,
  parameter int CNT_W  = $clog2(N_BITS + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic             i_step,
  input  logic             i_abort,
  input  logic [CNT_W-1:0] i_len,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_last,
  output logic             o_k,
  output logic             o_busy,
  output logic             o_done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LP_MAX_LEN = CNT_W'(N_BITS);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_len;
  logic             r_k;
  logic             r_done;

  logic [CNT_W-1:0] w_len_eff;
  logic [CNT_W-1:0] w_last_idx;
  logic             w_at_last;

`ifdef ITER_COUNTER_LEN_EN
  // A zero or oversize request falls back to the full operand width.
  always_comb begin
    w_len_eff = i_len;
    if ((i_len == '0) || (i_len > LP_MAX_LEN)) begin
      w_len_eff = LP_MAX_LEN;
    end
  end
`else
  logic w_unused_len;
  assign w_unused_len = ^i_len;
  assign w_len_eff    = LP_MAX_LEN;
`endif

  // r_len is always >= 1, so the subtraction cannot underflow.
  assign w_last_idx = r_len - CNT_W'(1);
  assign w_at_last  = (r_cnt == w_last_idx);

  always_ff @(posedge i_clk) begin
    if (i_rst || i_abort) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_len   <= LP_MAX_LEN;
      r_k     <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_load) begin
        // Load restarts from any state; a pending final step is discarded.
        r_state <= S_RUN;
        r_cnt   <= '0;
        r_len   <= w_len_eff;
        r_k     <= 1'b0;
      end else begin
        case (r_state)
          S_RUN: begin
            if (i_step) begin
              if (w_at_last) begin
                r_state <= S_DONE;
                r_k     <= 1'b1;
                r_done  <= 1'b1;
              end else begin
                r_cnt <= r_cnt + CNT_W'(1);
              end
            end
          end
          S_DONE: begin
            r_k <= 1'b1;
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign o_cnt  = r_cnt;
  assign o_busy = (r_state == S_RUN);
  assign o_last = o_busy && w_at_last;
  assign o_k    = r_k;
  assign o_done = r_done;

endmodule
